spi_byte_sequencer: RTL and testbench

SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

---
 rtl/spi_seq_pkg.sv | 15 +
 rtl/spi_seq_buf.sv | 42 ++++
 rtl/spi_byte_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_spi_byte_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and default sizing for the SPI byte sequencer.
package spi_seq_pkg;

    localparam int unsigned SEQ_DATA_WIDTH = 8;
    localparam int unsigned SEQ_DEPTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

endpackage

// File: rtl/spi_seq_buf.sv
// DEPTH x DATA_WIDTH register file: one write port, one registered read port
// with read enable. Contents and read register clear on reset.
module spi_seq_buf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     i_sys_clk,
    input  logic                     i_reset_n,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array: written on wr_en_i, zeroed by reset.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; a same-edge write shows up on the following read.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spi_byte_sequencer.sv
// Sequences up to DEPTH bytes from a TX buffer through an external SPI byte
// driver, storing returned bytes in an RX buffer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; buffers host-accessible
// LAUNCH | load spi_tx_data from tx_buf[idx], pulse spi_en next cycle
// WAIT   | waiting for spi_done or timeout
// GAP    | GAP_CYCLES idle cycles before the next byte
// FINISH | register done pulse and drop busy
module spi_byte_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SEQ_DATA_WIDTH,
    parameter int unsigned DEPTH      = SEQ_DEPTH,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                       i_sys_clk,
    input  logic                       i_reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       spi_en,
    output logic [DATA_WIDTH-1:0]      spi_tx_data,
    input  logic                       spi_done,
    input  logic [DATA_WIDTH-1:0]      spi_rx_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_e    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          spi_en_q, spi_en_d;
    logic          tx_rd_en;
    logic          rx_wr_en;
    logic          tx_wr_en;
    logic          len_ok;
    logic          last_byte;

    assign len_ok    = (len != '0) && (len <= DEPTH_L);
    assign last_byte = ({1'b0, idx_q} == (len_q - LW'(1)));
    // Host writes are blocked for the whole transfer so the TX data cannot shift under the driver.
    assign tx_wr_en  = wr_en && !busy_q;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        spi_en_d = 1'b0;
        tx_rd_en = 1'b0;
        rx_wr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = len;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_LAUNCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                tx_rd_en = 1'b1;
                spi_en_d = 1'b1;
                tmo_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_done) begin
                    rx_wr_en = 1'b1;
                    if (last_byte) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d = idx_q + AW'(1);
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_LAUNCH;
                        end else begin
                            gap_d   = GAP_LOAD;
                            state_d = ST_GAP;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_LAUNCH;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            spi_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            spi_en_q <= spi_en_d;
        end
    end

    // TX read register only advances in LAUNCH, so spi_tx_data holds between bytes.
    spi_seq_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_tx_buf (
        .i_sys_clk  (i_sys_clk),
        .i_reset_n  (i_reset_n),
        .wr_en_i    (tx_wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_en_i    (tx_rd_en),
        .rd_addr_i  (idx_q),
        .rd_data_o  (spi_tx_data)
    );

    spi_seq_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rx_buf (
        .i_sys_clk  (i_sys_clk),
        .i_reset_n  (i_reset_n),
        .wr_en_i    (rx_wr_en),
        .wr_addr_i  (idx_q),
        .wr_data_i  (spi_rx_data),
        .rd_en_i    (1'b1),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign spi_en = spi_en_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a loop-back SPI driver model.
module tb_spi_byte_sequencer;

    logic       i_sys_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       start = 1'b0;
    logic [4:0] len = '0;
    logic       busy, done, err, spi_en;
    logic [7:0] spi_tx_data;
    logic       spi_done = 1'b0;
    logic [7:0] spi_rx_data = '0;

    spi_byte_sequencer dut (
        .i_sys_clk   (i_sys_clk),
        .i_reset_n   (i_reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .start       (start),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .spi_en      (spi_en),
        .spi_tx_data (spi_tx_data),
        .spi_done    (spi_done),
        .spi_rx_data (spi_rx_data)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // driver model and event monitor state
    int         drv_lat  = 40;
    bit         drv_mute = 1'b0;
    int         drv_cnt  = 0;
    logic [7:0] drv_tx   = '0;
    logic [7:0] drv_tx_last = '0;
    int         en_cnt = 0, done_cnt = 0, sdone_cnt = 0;
    int         en_cyc_last = 0, en_cyc_prev = 0, done_cyc = 0;
    logic       busy_prev = 1'b0, busy_at_done = 1'b0, busy_before_done = 1'b0;

    always @(posedge i_sys_clk) cyc++;

    // Loop-back driver: answers ~tx drv_lat cycles after spi_en; also logs events.
    always @(negedge i_sys_clk) begin
        spi_done = 1'b0;
        if (drv_cnt > 0) begin
            drv_cnt--;
            if (drv_cnt == 0) begin
                spi_done    = 1'b1;
                spi_rx_data = ~drv_tx;
                sdone_cnt++;
            end
        end
        if (spi_en) begin
            en_cnt++;
            en_cyc_prev = en_cyc_last;
            en_cyc_last = cyc;
            drv_tx_last = spi_tx_data;
            if (!drv_mute) begin
                drv_cnt = drv_lat;
                drv_tx  = spi_tx_data;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc         = cyc;
            busy_at_done     = busy;
            busy_before_done = busy_prev;
        end
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_tx(input logic [3:0] a, input logic [7:0] d);
        @(negedge i_sys_clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge i_sys_clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] l);
        @(negedge i_sys_clk);
        start = 1'b1; len = l;
        @(negedge i_sys_clk);
        start = 1'b0;
    endtask

    task automatic read_rx(input logic [3:0] a, output logic [7:0] d);
        @(negedge i_sys_clk);
        rd_addr = a;
        @(negedge i_sys_clk);
        d = rd_data;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int d0 = done_cnt;
        for (int i = 0; i < max_cyc && done_cnt == d0; i++) @(negedge i_sys_clk);
        check(tag, done_cnt - d0, 1);
    endtask

    initial begin
        logic [7:0] rv;
        int e0, d0, s0;

        // reset state
        repeat (3) @(negedge i_sys_clk);
        check("rst_busy", busy, 0);
        check("rst_outs", {done, err, spi_en}, 0);
        check("rst_tx", spi_tx_data, 0);
        check("rst_rd", rd_data, 0);
        i_reset_n = 1'b1;

        // three-byte loop-back transfer
        write_tx(4'd0, 8'hA5);
        write_tx(4'd1, 8'h3C);
        write_tx(4'd2, 8'h81);
        e0 = en_cnt; d0 = done_cnt;
        drv_lat = 40;
        pulse_start(5'd3);
        check("t3_busy", busy, 1);
        wait_done("t3_done", 1000);
        @(negedge i_sys_clk);
        check("t3_en_pulses", en_cnt - e0, 3);
        check("t3_done_pulses", done_cnt - d0, 1);
        check("t3_err", err, 0);
        check("t3_period", en_cyc_last - en_cyc_prev, 46);
        read_rx(4'd0, rv); check("t3_rx0", rv, 8'h5A);
        read_rx(4'd1, rv); check("t3_rx1", rv, 8'hC3);
        read_rx(4'd2, rv); check("t3_rx2", rv, 8'h7E);

        // invalid lengths
        e0 = en_cnt;
        pulse_start(5'd0);
        check("len0_err", err, 1);
        check("len0_busy", busy, 0);
        pulse_start(5'd17);
        check("len17_err", err, 1);
        check("len17_busy", busy, 0);
        repeat (5) @(negedge i_sys_clk);
        check("badlen_no_en", en_cnt - e0, 0);
        pulse_start(5'd1);
        check("valid_clears_err", err, 0);
        check("valid_busy", busy, 1);
        wait_done("valid_done", 1000);

        // timeout: driver never answers
        drv_mute = 1'b1;
        pulse_start(5'd1);
        wait_done("tmo_done", 5000);
        check("tmo_latency", done_cyc - en_cyc_last, 4097);
        check("tmo_err", err, 1);
        check("tmo_busy_at_done", busy_at_done, 0);
        check("tmo_busy_before", busy_before_done, 1);
        drv_mute = 1'b0;

        // start and wr_en while busy are ignored
        e0 = en_cnt; d0 = done_cnt;
        pulse_start(5'd1);
        repeat (5) @(negedge i_sys_clk);
        start = 1'b1; len = 5'd2; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
        @(negedge i_sys_clk);
        start = 1'b0; wr_en = 1'b0;
        wait_done("busy_ign_done", 1000);
        repeat (5) @(negedge i_sys_clk);
        check("busy_ign_en", en_cnt - e0, 1);
        check("busy_ign_dn", done_cnt - d0, 1);
        pulse_start(5'd1);
        wait_done("busy_ign_done2", 1000);
        check("busy_ign_tx_kept", drv_tx_last, 8'hA5);

        // write coinciding with start commits before the launch
        @(negedge i_sys_clk);
        start = 1'b1; len = 5'd1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
        @(negedge i_sys_clk);
        start = 1'b0; wr_en = 1'b0;
        wait_done("coinc_done", 1000);
        check("coinc_tx", drv_tx_last, 8'h11);
        read_rx(4'd0, rv); check("coinc_rx0", rv, 8'hEE);

        // reset mid-transfer after the second byte
        drv_lat = 10;
        s0 = sdone_cnt;
        pulse_start(5'd4);
        for (int i = 0; i < 200 && sdone_cnt - s0 < 2; i++) @(negedge i_sys_clk);
        check("mid_two_bytes", sdone_cnt - s0, 2);
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_outs", {done, err, spi_en}, 0);
        check("mid_rst_tx", spi_tx_data, 0);
        check("mid_rst_rd", rd_data, 0);
        @(negedge i_sys_clk);
        i_reset_n = 1'b1; start = 1'b1; len = 5'd1;
        @(negedge i_sys_clk);
        start = 1'b0;
        check("post_rst_accept", busy, 1);
        wait_done("post_rst_done", 1000);
        check("post_rst_tx_zero", drv_tx_last, 8'h00);
        check("post_rst_err", err, 0);
        read_rx(4'd0, rv); check("post_rst_rx0", rv, 8'hFF);
        read_rx(4'd1, rv); check("post_rst_rx1_clr", rv, 8'h00);

        // spi_en spacing with 10-cycle driver latency
        write_tx(4'd0, 8'h12);
        write_tx(4'd1, 8'h34);
        drv_lat = 10;
        pulse_start(5'd2);
        wait_done("gap_done", 1000);
        check("gap_period", en_cyc_last - en_cyc_prev, 16);
        read_rx(4'd0, rv); check("gap_rx0", rv, 8'hED);
        read_rx(4'd1, rv); check("gap_rx1", rv, 8'hCB);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
